uart_byte_receiver: RTL

Oversampling UART receive front end that feeds the boot loader's byte-assembly stage. It synchronises the raw uart_rx pin, qualifies start bits, and samples 8N1 frames LSB-first using a 3-sample majority vote. It presents each good byte as a one-cycle rx_valid strobe with rx_data. Framing errors are reported on a sticky flag and never reach the loader as data.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_byte_receiver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit blocks.
package uart_pkg;

    // Receiver framing states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_A   = 7;
    localparam int unsigned SAMPLE_B   = 8;
    localparam int unsigned SAMPLE_C   = 9;
    localparam int unsigned DATA_BITS  = 8;

    // 2-of-3 vote used to reject single-sample line noise
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..CLKS_PER_TICK-1 and pulses tick on the
// terminal count. A synchronous restart realigns the phase to an external event.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_TICK - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Terminal-count detect
    always_comb begin
        tick = (cnt_q == CntMax);
    end

    // Next count: restart wins, otherwise wrap at terminal count
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Good bytes appear as a one-cycle rx_valid strobe; bad stop bits set a sticky
// framing_err and the byte is dropped.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_e state_q, state_d;

    logic       tick;
    logic       restart;
    logic [3:0] s_q;
    logic       samp_a_q, samp_b_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       framing_err_q;

    logic decide, wrap, maj;
    logic shift_en, clr_count, load_byte, set_err;

    // Input synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    // Sample-point decode; the third vote is the live rx_s at the decision tick
    always_comb begin
        decide = tick && (s_q == 4'(SAMPLE_C));
        wrap   = tick && (s_q == 4'(OVERSAMPLE - 1));
        maj    = majority3(samp_a_q, samp_b_q, rx_s);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (wrap && (bit_cnt_q == 4'(DATA_BITS))) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave at mid-stop-bit so back-to-back frames are not missed
                if (decide) begin
                    state_d = maj ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (tick && rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        busy      = (state_q != StIdle);
        // In BREAK a low line keeps resetting the counter, so exit needs a full high tick
        restart   = ((state_q == StIdle) || (state_q == StBreak)) && !rx_s;
        clr_count = (state_q == StStart) && wrap;
        shift_en  = (state_q == StData) && decide;
        load_byte = (state_q == StStop) && decide && maj;
        set_err   = (state_q == StStop) && decide && !maj;
    end

    // Sample index and majority sample capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            if (state_q == StIdle) begin
                s_q <= '0;
            end else if (tick) begin
                s_q <= s_q + 4'd1;
            end
            if (tick && (s_q == 4'(SAMPLE_A))) begin
                samp_a_q <= rx_s;
            end
            if (tick && (s_q == 4'(SAMPLE_B))) begin
                samp_b_q <= rx_s;
            end
        end
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            if (clr_count) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (shift_en) begin
                shift_q <= {maj, shift_q[7:1]};
            end
        end
    end

    // Output byte, strobe and sticky error; set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            rx_valid_q <= load_byte;
            if (load_byte) begin
                rx_data_q <= shift_q;
            end
            if (set_err) begin
                framing_err_q <= 1'b1;
            end else if (err_clr) begin
                framing_err_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;

endmodule
